// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder, LSB first, one bit per clock.
// Define SERIAL_ADD_SUB_EN to add the sub port and subtract mode (a - b).

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_ready and out_valid decode only the registered state, so a producer
   // or consumer may wait on them without creating a combinational loop.

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic [WIDTH-1:0] sum_shift;
   logic             fa_s;
   logic             fa_co;

`ifdef SERIAL_ADD_SUB_EN
   // Two's-complement subtract: a + ~b + 1; cout=1 then means no borrow.
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   full_adder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // Each new sum bit enters at the MSB end; after WIDTH shifts bit 0 is in place.
   generate
      if (WIDTH == 1) begin : g_w1
         assign sum_shift = fa_s;
      end else begin : g_wn
         assign sum_shift = {fa_s, sum[WIDTH-1:1]};
      end
   endgenerate

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b_load;
                  carry <= c_load;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sum   <= sum_shift;
               cout  <= fa_co;
               carry <= fa_co;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               cnt   <= cnt + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
// Subtract tests are compiled in only when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   logic         w1_in_valid;
   logic         w1_in_ready;
   logic         w1_a;
   logic         w1_b;
   logic         w1_cin;
   logic         w1_sub;
   logic         w1_out_valid;
   logic         w1_out_ready;
   logic         w1_sum;
   logic         w1_cout;

   int n_checks = 0;
   int n_pass   = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w1_in_valid),
      .in_ready  (w1_in_ready),
      .a         (w1_a),
      .b         (w1_b),
      .cin       (w1_cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (w1_sub),
`endif
      .out_valid (w1_out_valid),
      .out_ready (w1_out_ready),
      .sum       (w1_sum),
      .cout      (w1_cout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: sim time expired, required completion");
      $fatal(1, "watchdog");
   end

   // Reference: arithmetic result {cout, sum} of one request.
   function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic cv, input logic sv);
      longint r;
      if (sv) begin
         r = longint'(av) - longint'(bv);
         return {(av >= bv), r[W-1:0]};
      end
      r = longint'(av) + longint'(bv) + longint'(cv);
      return r[W:0];
   endfunction

   // Drive one request, optionally scribbling on inputs while busy, and
   // return the result once out_valid is seen (lat = edges after accept).
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic sv, input bit noise,
                         output logic [W-1:0] s_o, output logic c_o, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1;
      a = av;
      b = bv;
      cin = cv;
      sub = sv;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         lat++;
         #1;
         @(negedge clk);
      end while (!out_valid && lat < 100);
      in_valid = 1'b0;
      s_o = sum;
      c_o = cout;
   endtask

   task automatic release_op(input int delay, input bit keep);
      repeat (delay) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      if (!keep) out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
      w1_in_valid = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_cin = 1'b0; w1_sub = 1'b0;
      w1_out_ready = 1'b0;
      #12;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", in_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b need 0", out_valid);
      else n_pass++;
      n_checks++;
      if (sum !== '0) $display("FAIL reset_sum: got %h need 00", sum);
      else n_pass++;
      n_checks++;
      if (cout !== 1'b0) $display("FAIL reset_cout: got %b need 0", cout);
      else n_pass++;
      n_checks++;
      if ({w1_in_ready, w1_out_valid, w1_sum, w1_cout} !== 4'b1000)
         $display("FAIL reset_w1: got rdy/vld/sum/cout=%b%b%b%b need 1000",
                  w1_in_ready, w1_out_valid, w1_sum, w1_cout);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [W-1:0] av[3] = '{8'h3C, 8'hFF, 8'hFF};
      logic [W-1:0] bv[3] = '{8'h42, 8'h01, 8'hFF};
      logic         cv[3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] es[3] = '{8'h7E, 8'h00, 8'hFF};
      logic         ec[3] = '{1'b0, 1'b1, 1'b1};
      logic [W-1:0] s;
      logic         c;
      int           lat;
      for (int i = 0; i < 3; i++) begin
         run_op(av[i], bv[i], cv[i], 1'b0, 1'b0, s, c, lat);
         n_checks++;
         if (lat !== W) $display("FAIL directed_latency[%0d]: got %0d need %0d", i, lat, W);
         else n_pass++;
         n_checks++;
         if (s !== es[i]) $display("FAIL directed_sum[%0d]: got %h need %h", i, s, es[i]);
         else n_pass++;
         n_checks++;
         if (c !== ec[i]) $display("FAIL directed_cout[%0d]: got %b need %b", i, c, ec[i]);
         else n_pass++;
         release_op(0, 1'b0);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] av, bv, s;
      logic         cv, sv, c;
      logic [W:0]   exp_r;
      int           lat;
      for (int i = 0; i < 16; i++) begin
         av = W'($urandom);
         bv = W'($urandom);
         cv = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
         sv = 1'($urandom_range(0, 1));
`else
         sv = 1'b0;
`endif
         exp_r = model(av, bv, cv, sv);
         run_op(av, bv, cv, sv, 1'b1, s, c, lat);
         n_checks++;
         if (lat !== W) $display("FAIL random_latency[%0d]: got %0d need %0d", i, lat, W);
         else n_pass++;
         n_checks++;
         if ({c, s} !== exp_r)
            $display("FAIL random_result[%0d]: a=%h b=%h cin=%b sub=%b got %b/%h need %b/%h",
                     i, av, bv, cv, sv, c, s, exp_r[W], exp_r[W-1:0]);
         else n_pass++;
         release_op($urandom_range(0, 3), 1'b0);
      end
   endtask

   task automatic test_stall();
      logic [W-1:0] s0;
      logic         c0;
      logic [W:0]   exp_r;
      int           lat;
      exp_r = model(8'h5A, 8'h33, 1'b1, 1'b0);
      run_op(8'h5A, 8'h33, 1'b1, 1'b0, 1'b0, s0, c0, lat);
      n_checks++;
      if ({c0, s0} !== exp_r) $display("FAIL stall_result: got %b/%h need %b/%h",
                                       c0, s0, exp_r[W], exp_r[W-1:0]);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_checks++;
         if ({sum, cout, in_ready, out_valid} !== {exp_r[W-1:0], exp_r[W], 1'b0, 1'b1})
            $display("FAIL stall_hold[%0d]: got sum=%h cout=%b rdy=%b vld=%b need %h %b 0 1",
                     i, sum, cout, in_ready, out_valid, exp_r[W-1:0], exp_r[W]);
         else n_pass++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL stall_release: got rdy=%b vld=%b need 1 0", in_ready, out_valid);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({sum, cout} !== {exp_r[W-1:0], exp_r[W]})
         $display("FAIL stall_idle_visible: got %h/%b need %h/%b",
                  sum, cout, exp_r[W-1:0], exp_r[W]);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic [W-1:0] s;
      logic         c;
      int           lat;
      in_valid = 1'b1;
      a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL abort_flags: got rdy=%b vld=%b need 1 0", in_ready, out_valid);
      else n_pass++;
      n_checks++;
      if ({sum, cout} !== '0) $display("FAIL abort_data: got %h/%b need 00/0", sum, cout);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, s, c, lat);
      n_checks++;
      if ({c, s, lat} !== {1'b0, 8'h03, W})
         $display("FAIL abort_next_op: got %b/%h lat %0d need 0/03 lat %0d", c, s, lat, W);
      else n_pass++;
      release_op(0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] av, bv, s;
      logic         cv, c;
      logic [W:0]   exp_r;
      int           lat;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         av = W'($urandom);
         bv = W'($urandom);
         cv = 1'($urandom_range(0, 1));
         exp_r = model(av, bv, cv, 1'b0);
         run_op(av, bv, cv, 1'b0, 1'b0, s, c, lat);
         n_checks++;
         if ({c, s} !== exp_r || lat != W)
            $display("FAIL b2b[%0d]: got %b/%h lat %0d need %b/%h lat %0d",
                     i, c, s, lat, exp_r[W], exp_r[W-1:0], W);
         else n_pass++;
         release_op(0, 1'b1);
      end
      out_ready = 1'b0;
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      logic [W-1:0] s;
      logic         c;
      int           lat;
      run_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b0, s, c, lat);
      n_checks++;
      if ({c, s} !== {1'b0, 8'hF0}) $display("FAIL sub_borrow: got %b/%h need 0/F0", c, s);
      else n_pass++;
      release_op(0, 1'b0);
      run_op(8'h20, 8'h10, 1'b0, 1'b1, 1'b0, s, c, lat);
      n_checks++;
      if ({c, s} !== {1'b1, 8'h10}) $display("FAIL sub_no_borrow: got %b/%h need 1/10", c, s);
      else n_pass++;
      release_op(0, 1'b0);
   endtask
`endif

   task automatic run_op1(input logic av, input logic bv, input logic cv,
                          output logic s_o, output logic c_o, output int lat);
      int guard;
      guard = 0;
      while (!w1_in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      w1_in_valid = 1'b1;
      w1_a = av;
      w1_b = bv;
      w1_cin = cv;
      @(posedge clk);
      #1;
      w1_in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
         @(negedge clk);
      end while (!w1_out_valid && lat < 100);
      s_o = w1_sum;
      c_o = w1_cout;
   endtask

   task automatic test_width1();
      logic av, bv, cv, s, c;
      int   lat;
      int   tot;
      run_op1(1'b1, 1'b1, 1'b1, s, c, lat);
      n_checks++;
      if ({c, s} !== 2'b11 || lat != 1)
         $display("FAIL w1_directed: got %b/%b lat %0d need 1/1 lat 1", c, s, lat);
      else n_pass++;
      w1_out_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         av = 1'($urandom_range(0, 1));
         bv = 1'($urandom_range(0, 1));
         cv = 1'($urandom_range(0, 1));
         tot = int'(av) + int'(bv) + int'(cv);
         run_op1(av, bv, cv, s, c, lat);
         n_checks++;
         if (int'({c, s}) != tot || lat != 1)
            $display("FAIL w1_b2b[%0d]: got %b/%b lat %0d need total %0d lat 1",
                     i, c, s, lat, tot);
         else n_pass++;
         @(posedge clk);
         #1;
      end
      w1_out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_stall();
      test_abort();
      test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      test_width1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
